// File: rtl/vga_mode_sequencer.sv
// Sequences run-time video-mode changes: blank, wait for frame end, hold the generator in
// reset, settle for whole frames, then unblank. Define VGA_MODE_SEQ_TIMEOUT_EN for the watchdog.
module vga_mode_sequencer #(
    parameter int unsigned DEFAULT_MODE   = 3,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned SETTLE_FRAMES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [1:0]  req_mode,
    output logic        req_ready,
    input  logic [10:0] hpos,
    input  logic [9:0]  vpos,
    output logic [1:0]  mode,
    output logic        gen_reset,
    output logic        blank,
    output logic        busy,
    output logic        done,
    output logic        timeout
);

    typedef enum logic [1:0] {
        StRun,
        StWaitSof,
        StHold,
        StSettle
    } state_t;

    localparam logic [1:0] ModeInit   = 2'(DEFAULT_MODE);
    localparam logic [7:0] HoldLast   = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0] SettleInit = 4'(SETTLE_FRAMES);

    if (DEFAULT_MODE > 3 || HOLD_CYCLES < 1 || HOLD_CYCLES > 255 || SETTLE_FRAMES > 15 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 2097152) begin : g_bad_param
        $error("vga_mode_sequencer: parameter out of range");
    end

    state_t     state;
    logic [1:0] pending;
    logic [7:0] hold_cnt;
    logic [3:0] settle_cnt;
    logic       sof_pos;
    logic       sof;
    logic       req_fire;

    // Position (0,0) only counts while the generator is actually running.
    assign sof_pos   = (hpos == 11'd0) && (vpos == 10'd0) && !gen_reset;
    assign req_ready = (state == StRun) && !reset;
    assign req_fire  = req_valid && req_ready;

`ifdef VGA_MODE_SEQ_TIMEOUT_EN
    localparam logic [20:0] WdLast = 21'(TIMEOUT_CYCLES - 1);

    logic [20:0] wd_cnt;
    logic        wd_waiting;
    logic        wd_hit;

    assign wd_waiting = (state == StWaitSof) || (state == StSettle);
    assign wd_hit     = wd_waiting && (wd_cnt == WdLast);
    // A stalled position input is treated as if the frame had ended.
    assign sof        = sof_pos || wd_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt  <= 21'd0;
            timeout <= 1'b0;
        end else begin
            if (wd_waiting && !sof) begin
                wd_cnt <= wd_cnt + 21'd1;
            end else begin
                wd_cnt <= 21'd0;
            end
            if (wd_hit) begin
                timeout <= 1'b1;
            end else if (req_fire) begin
                timeout <= 1'b0;
            end
        end
    end
`else
    assign sof     = sof_pos;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StHold;
            mode       <= ModeInit;
            pending    <= ModeInit;
            gen_reset  <= 1'b1;
            blank      <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            hold_cnt   <= HoldLast;
            settle_cnt <= SettleInit;
        end else begin
            done <= 1'b0;
            unique case (state)
                StRun: begin
                    if (req_fire) begin
                        if (req_mode == mode) begin
                            done <= 1'b1;
                        end else begin
                            pending <= req_mode;
                            blank   <= 1'b1;
                            busy    <= 1'b1;
                            state   <= StWaitSof;
                        end
                    end
                end
                StWaitSof: begin
                    // Old mode keeps running until its frame completes.
                    if (sof) begin
                        mode      <= pending;
                        gen_reset <= 1'b1;
                        hold_cnt  <= HoldLast;
                        state     <= StHold;
                    end
                end
                StHold: begin
                    if (hold_cnt == 8'd0) begin
                        gen_reset  <= 1'b0;
                        settle_cnt <= SettleInit;
                        state      <= StSettle;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                StSettle: begin
                    // First sof lands right after release, so SettleInit whole frames stay black.
                    if (sof) begin
                        if (settle_cnt != 4'd0) begin
                            settle_cnt <= settle_cnt - 4'd1;
                        end else begin
                            blank <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StRun;
                        end
                    end
                end
                default: state <= StHold;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Directed bench for vga_mode_sequencer with a small 8x3 frame model driving hpos/vpos.
module tb_vga_mode_sequencer;

    localparam int unsigned Hold   = 4;
    localparam int unsigned Settle = 2;
    localparam int unsigned Tmo    = 1000;
    localparam int          HTot   = 8;
    localparam int          Frame  = 24;
    localparam int          NVec   = 31;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_mode = 2'd0;
    logic        req_ready;
    logic [10:0] hpos = 11'd0;
    logic [9:0]  vpos = 10'd0;
    logic [1:0]  mode;
    logic        gen_reset;
    logic        blank;
    logic        busy;
    logic        done;
    logic        timeout;

    int errors = 0;
    int checks = 0;
    int cnt = 0;
    bit freeze = 1'b0;

    typedef struct {
        logic       valid;
        logic [1:0] rmode;
        int         ticks;
        logic [1:0] mode;
        logic       gr;
        logic       blank;
        logic       busy;
        logic       done;
        logic       ready;
    } vec_t;

    vec_t vecs[NVec];

    vga_mode_sequencer #(
        .DEFAULT_MODE  (3),
        .HOLD_CYCLES   (Hold),
        .SETTLE_FRAMES (Settle),
        .TIMEOUT_CYCLES(Tmo)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_mode (req_mode),
        .req_ready(req_ready),
        .hpos     (hpos),
        .vpos     (vpos),
        .mode     (mode),
        .gen_reset(gen_reset),
        .blank    (blank),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got no finish required finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic drive_pos();
        if (freeze) begin
            hpos = 11'd5;
            vpos = 10'd5;
        end else begin
            hpos = 11'(cnt % HTot);
            vpos = 10'(cnt / HTot);
        end
    endtask

    // Generator model: counters sit at 0 while held in reset, then advance one per clock.
    task automatic tick();
        logic prev_gr;
        prev_gr = gen_reset;
        @(posedge clk);
        #1;
        if (prev_gr === 1'b1) cnt = 0;
        else cnt = (cnt + 1) % Frame;
        drive_pos();
    endtask

    function automatic vec_t mk(int v, int rm, int t, int m, int g, int b, int bs, int d, int r);
        vec_t x;
        x.valid = 1'(v);
        x.rmode = 2'(rm);
        x.ticks = t;
        x.mode  = 2'(m);
        x.gr    = 1'(g);
        x.blank = 1'(b);
        x.busy  = 1'(bs);
        x.done  = 1'(d);
        x.ready = 1'(r);
        return x;
    endfunction

    initial begin
        int n;
        //                valid rm ticks  mode gr blank busy done ready
        vecs[0]  = mk(0, 0, 0,  3, 1, 1, 1, 0, 0);  // right after release
        vecs[1]  = mk(0, 0, 3,  3, 1, 1, 1, 0, 0);
        vecs[2]  = mk(0, 0, 1,  3, 0, 1, 1, 0, 0);  // 4th cycle ends the hold
        vecs[3]  = mk(0, 0, 48, 3, 0, 1, 1, 0, 0);
        vecs[4]  = mk(0, 0, 1,  3, 0, 0, 0, 1, 1);  // 3rd sof
        vecs[5]  = mk(0, 0, 1,  3, 0, 0, 0, 0, 1);
        vecs[6]  = mk(1, 3, 1,  3, 0, 0, 0, 1, 1);  // same-mode request
        vecs[7]  = mk(0, 0, 1,  3, 0, 0, 0, 0, 1);
        vecs[8]  = mk(1, 0, 1,  3, 0, 1, 1, 0, 0);  // switch to 0
        vecs[9]  = mk(0, 0, 19, 3, 0, 1, 1, 0, 0);
        vecs[10] = mk(0, 0, 1,  0, 1, 1, 1, 0, 0);
        vecs[11] = mk(0, 0, 3,  0, 1, 1, 1, 0, 0);
        vecs[12] = mk(0, 0, 1,  0, 0, 1, 1, 0, 0);
        vecs[13] = mk(0, 0, 48, 0, 0, 1, 1, 0, 0);
        vecs[14] = mk(0, 0, 1,  0, 0, 0, 0, 1, 1);
        vecs[15] = mk(1, 2, 1,  0, 0, 1, 1, 0, 0);  // switch to 2
        vecs[16] = mk(1, 1, 22, 0, 0, 1, 1, 0, 0);  // mode 1 held while busy
        vecs[17] = mk(1, 1, 1,  2, 1, 1, 1, 0, 0);
        vecs[18] = mk(1, 1, 4,  2, 0, 1, 1, 0, 0);
        vecs[19] = mk(1, 1, 48, 2, 0, 1, 1, 0, 0);
        vecs[20] = mk(1, 1, 1,  2, 0, 0, 0, 1, 1);
        vecs[21] = mk(1, 1, 1,  2, 0, 1, 1, 0, 0);  // held request taken on first RUN cycle
        vecs[22] = mk(0, 0, 22, 2, 0, 1, 1, 0, 0);
        vecs[23] = mk(0, 0, 1,  1, 1, 1, 1, 0, 0);
        vecs[24] = mk(0, 0, 4,  1, 0, 1, 1, 0, 0);
        vecs[25] = mk(0, 0, 49, 1, 0, 0, 0, 1, 1);
        vecs[26] = mk(0, 0, 1,  1, 0, 0, 0, 0, 1);
        vecs[27] = mk(1, 2, 1,  1, 0, 1, 1, 0, 0);  // switch to 2, then reset in SETTLE
        vecs[28] = mk(0, 0, 22, 2, 1, 1, 1, 0, 0);
        vecs[29] = mk(0, 0, 4,  2, 0, 1, 1, 0, 0);
        vecs[30] = mk(0, 0, 5,  2, 0, 1, 1, 0, 0);

        reset = 1'b1;
        tick();
        tick();
        check("rst_mode", mode, 3);
        check("rst_gen_reset", gen_reset, 1);
        check("rst_blank", blank, 1);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_ready", req_ready, 0);
        reset = 1'b0;

        for (int i = 0; i < NVec; i++) begin
            req_valid = vecs[i].valid;
            req_mode  = vecs[i].rmode;
            for (int k = 0; k < vecs[i].ticks; k++) tick();
            check($sformatf("v%0d_mode", i), mode, vecs[i].mode);
            check($sformatf("v%0d_gen_reset", i), gen_reset, vecs[i].gr);
            check($sformatf("v%0d_blank", i), blank, vecs[i].blank);
            check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("v%0d_done", i), done, vecs[i].done);
            check($sformatf("v%0d_ready", i), req_ready, vecs[i].ready);
            check($sformatf("v%0d_timeout", i), timeout, 0);
        end
        req_valid = 1'b0;

        // Reset mid-SETTLE drops the pending mode 2 and replays power-up.
        reset = 1'b1;
        tick();
        check("midrst_mode", mode, 3);
        check("midrst_gen_reset", gen_reset, 1);
        check("midrst_blank", blank, 1);
        check("midrst_busy", busy, 1);
        check("midrst_done", done, 0);
        reset = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("midrst_cycles_to_done", n, 53);
        check("midrst_final_mode", mode, 3);
        check("midrst_final_blank", blank, 0);

        // Frozen position input.
        freeze = 1'b1;
        drive_pos();
        req_valid = 1'b1;
        req_mode  = 2'd0;
        tick();
        req_valid = 1'b0;
        check("frz_busy", busy, 1);
        check("frz_blank", blank, 1);
        repeat (Tmo - 1) tick();
        check("frz_pre_mode", mode, 3);
        check("frz_pre_gen_reset", gen_reset, 0);
        check("frz_pre_timeout", timeout, 0);
        tick();
`ifdef VGA_MODE_SEQ_TIMEOUT_EN
        check("wd_mode", mode, 0);
        check("wd_gen_reset", gen_reset, 1);
        check("wd_timeout", timeout, 1);
        n = 0;
        while (done !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        check("wd_cycles_to_done", n, 3004);
        check("wd_timeout_sticky", timeout, 1);
        check("wd_final_mode", mode, 0);
        freeze = 1'b0;
        drive_pos();
`else
        check("frz_mode", mode, 3);
        check("frz_gen_reset", gen_reset, 0);
        check("frz_timeout", timeout, 0);
        repeat (500) tick();
        check("frz_still_busy", busy, 1);
        check("frz_still_mode", mode, 3);
        freeze = 1'b0;
        drive_pos();
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("frz_done_seen", (n < 200) ? 1 : 0, 1);
        check("frz_final_mode", mode, 0);
        check("frz_final_timeout", timeout, 0);
`endif

        // Same-mode request clears a sticky timeout.
        req_valid = 1'b1;
        req_mode  = 2'd0;
        tick();
        req_valid = 1'b0;
        check("same_done", done, 1);
        check("same_timeout", timeout, 0);
        check("same_blank", blank, 0);
        tick();
        check("run_ready", req_ready, 1);
        reset = 1'b1;
        #1;
        check("ready_in_reset", req_ready, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
